// File: rtl/mux3_arb_pkg.sv
// Shared types and select encodings for the three-way round-robin arbiter.
// Select codes double as the round-robin pointer value.
package mux3_arb_pkg;

   typedef enum logic {IDLE, FULL} arb_state_t;

   localparam logic [1:0] SEL_D0 = 2'b00;
   localparam logic [1:0] SEL_D1 = 2'b01;
   localparam logic [1:0] SEL_D2 = 2'b10;

endpackage

// File: rtl/mux3.sv
// Three-input data multiplexer steered by a 2-bit select.
// Select 2'b11 is never produced upstream and yields zero.
module mux3
   import mux3_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      unique case (sel)
         SEL_D0:  y = d0;
         SEL_D1:  y = d1;
         SEL_D2:  y = d2;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/rr_pick3.sv
// Combinational round-robin pick: search last+1, last+2, last.
// hold forces the previous winner to win again when it is still requesting.
module rr_pick3
   import mux3_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   input  logic       hold,
   output logic [2:0] win,
   output logic [1:0] wsel
);

   always_comb begin
      win = 3'b000;
      if (hold) begin
         unique case (last)
            SEL_D0:  win = 3'b001;
            SEL_D1:  win = 3'b010;
            default: win = 3'b100;
         endcase
      end else begin
         unique case (last)
            SEL_D0: begin
               if (req[1])      win = 3'b010;
               else if (req[2]) win = 3'b100;
               else if (req[0]) win = 3'b001;
            end
            SEL_D1: begin
               if (req[2])      win = 3'b100;
               else if (req[0]) win = 3'b001;
               else if (req[1]) win = 3'b010;
            end
            default: begin
               if (req[0])      win = 3'b001;
               else if (req[1]) win = 3'b010;
               else if (req[2]) win = 3'b100;
            end
         endcase
      end
   end

   always_comb begin
      wsel = SEL_D0;
      unique case (1'b1)
         win[1]:  wsel = SEL_D1;
         win[2]:  wsel = SEL_D2;
         default: wsel = SEL_D0;
      endcase
   end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin share of one registered valid/ready channel among three requesters.
// Define ARB_LOCK_EN to add the lock port (burst mode: locked winner keeps priority).
module mux3_rr_arbiter
   import mux3_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       req,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
`ifdef ARB_LOCK_EN
   input  logic [2:0]       lock,
`endif
   output logic [2:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready
);

   arb_state_t       state;
   logic [1:0]       last;
   logic             load;
   logic             hold;
   logic [2:0]       win;
   logic [1:0]       wsel;
   logic [WIDTH-1:0] dmux;

`ifdef ARB_LOCK_EN
   always_comb begin
      hold = 1'b0;
      unique case (last)
         SEL_D0:  hold = req[0] & lock[0];
         SEL_D1:  hold = req[1] & lock[1];
         default: hold = req[2] & lock[2];
      endcase
   end
`else
   assign hold = 1'b0;
`endif

   rr_pick3 u_pick (
      .req  (req),
      .last (last),
      .hold (hold),
      .win  (win),
      .wsel (wsel)
   );

   mux3 #(.WIDTH(WIDTH)) u_mux (
      .sel (wsel),
      .d0  (d0),
      .d1  (d1),
      .d2  (d2),
      .y   (dmux)
   );

   // Consume and reload share one edge, so a held y_ready gives no bubble.
   assign load = (|req) && ((state == IDLE) || y_ready);
   assign gnt  = win & {3{load}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         y       <= '0;
         y_valid <= 1'b0;
         sel     <= SEL_D2;
         last    <= SEL_D2;
      end else if (load) begin
         state   <= FULL;
         y       <= dmux;
         y_valid <= 1'b1;
         sel     <= wsel;
         last    <= wsel;
      end else if ((state == FULL) && y_ready) begin
         state   <= IDLE;
         y_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Table-driven bench for mux3_rr_arbiter with a queue scoreboard of captures.
// Define ARB_LOCK_EN to also exercise the lock port.
module tb_mux3_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] req = '0;
   logic [7:0] d0 = '0, d1 = '0, d2 = '0;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic [7:0] y;
   logic       y_valid;
   logic       y_ready = 1'b0;
`ifdef ARB_LOCK_EN
   logic [2:0] lock = '0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] req;
      logic [7:0] d0, d1, d2;
      logic       rdy;
      logic [2:0] gnt;
      logic       vld;
   } vec_t;

   typedef struct {
      logic [7:0] y;
      logic [1:0] sel;
   } exp_t;

   vec_t tv[$];
   exp_t sb[$];
   logic [7:0] hold_y = '0;
   logic [1:0] hold_sel = 2'b10;

   mux3_rr_arbiter #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .d0      (d0),
      .d1      (d1),
      .d2      (d2),
`ifdef ARB_LOCK_EN
      .lock    (lock),
`endif
      .gnt     (gnt),
      .sel     (sel),
      .y       (y),
      .y_valid (y_valid),
      .y_ready (y_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] r, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c,
                      input logic rdy, input logic [2:0] g,
                      input logic v);
      vec_t t;
      t.req = r; t.d0 = a; t.d1 = b; t.d2 = c;
      t.rdy = rdy; t.gnt = g; t.vld = v;
      tv.push_back(t);
   endtask

   task automatic step(input vec_t v, input int idx);
      exp_t e;
      @(negedge clk);
      req = v.req; d0 = v.d0; d1 = v.d1; d2 = v.d2;
      y_ready = v.rdy;
      #1;
      chk($sformatf("gnt[%0d]", idx), {29'd0, gnt}, {29'd0, v.gnt});
      if (v.gnt != 3'b000) begin
         e.sel = v.gnt[1] ? 2'b01 : (v.gnt[2] ? 2'b10 : 2'b00);
         e.y   = v.gnt[1] ? v.d1 : (v.gnt[2] ? v.d2 : v.d0);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk($sformatf("y_valid[%0d]", idx), {31'd0, y_valid}, {31'd0, v.vld});
      if (v.gnt != 3'b000) begin
         if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", idx), 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("y[%0d]", idx), {24'd0, y}, {24'd0, e.y});
            chk($sformatf("sel[%0d]", idx), {30'd0, sel}, {30'd0, e.sel});
            hold_y = e.y;
            hold_sel = e.sel;
         end
      end else if (v.vld) begin
         chk($sformatf("y_hold[%0d]", idx), {24'd0, y}, {24'd0, hold_y});
         chk($sformatf("sel_hold[%0d]", idx), {30'd0, sel}, {30'd0, hold_sel});
      end
   endtask

   initial begin
      // rotation from reset pointer (d0 first)
      add(3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b001, 1'b1);
      add(3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b010, 1'b1);
      add(3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b100, 1'b1);
      add(3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 3'b001, 1'b1);
      add(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0);
      // single request
      add(3'b010, 8'h00, 8'hA5, 8'h00, 1'b1, 3'b010, 1'b1);
      // backpressure
      add(3'b100, 8'h00, 8'h00, 8'hC3, 1'b0, 3'b000, 1'b1);
      add(3'b100, 8'h00, 8'h00, 8'hC3, 1'b0, 3'b000, 1'b1);
      add(3'b100, 8'h00, 8'h00, 8'hC3, 1'b0, 3'b000, 1'b1);
      add(3'b100, 8'h00, 8'h00, 8'hC3, 1'b0, 3'b000, 1'b1);
      add(3'b100, 8'h00, 8'h00, 8'hC3, 1'b1, 3'b100, 1'b1);
      add(3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 3'b000, 1'b1);
      add(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0);
      // IDLE captures even without y_ready
      add(3'b001, 8'h5A, 8'h00, 8'h00, 1'b0, 3'b001, 1'b1);
      add(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0);
      // pointer at d0: d1 beats d0, then d2 beats d0
      add(3'b011, 8'h01, 8'h02, 8'h03, 1'b1, 3'b010, 1'b1);
      add(3'b101, 8'h04, 8'h05, 8'h06, 1'b1, 3'b100, 1'b1);
      add(3'b011, 8'h07, 8'h08, 8'h09, 1'b1, 3'b001, 1'b1);
      add(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 1'b0);

      #1 reset = 1'b1;
      #2;
      chk("rst_valid", {31'd0, y_valid}, 32'd0);
      chk("rst_y", {24'd0, y}, 32'd0);
      chk("rst_sel", {30'd0, sel}, 32'd2);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < tv.size(); i++) step(tv[i], i);

`ifdef ARB_LOCK_EN
      begin
         vec_t t;
         t.d0 = 8'hD0; t.d1 = 8'hD1; t.d2 = 8'hD2;
         t.rdy = 1'b1; t.vld = 1'b1;
         t.req = 3'b001; t.gnt = 3'b001;
         lock = 3'b000;
         step(t, 100);
         lock = 3'b001;
         t.req = 3'b011;
         for (int k = 0; k < 3; k++) step(t, 101 + k);
         lock = 3'b000;
         t.gnt = 3'b010;
         step(t, 104);
         t.req = 3'b000; t.gnt = 3'b000; t.vld = 1'b0;
         step(t, 105);
      end
`endif

      // async reset while FULL with backpressure
      begin
         vec_t t;
         t.req = 3'b001; t.d0 = 8'hEE; t.d1 = 8'h00; t.d2 = 8'h00;
         t.rdy = 1'b0; t.gnt = 3'b001; t.vld = 1'b1;
         step(t, 200);
      end
      @(negedge clk);
      req = 3'b000;
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, y_valid}, 32'd0);
      chk("mid_rst_y", {24'd0, y}, 32'd0);
      chk("mid_rst_sel", {30'd0, sel}, 32'd2);
      @(negedge clk);
      reset = 1'b0;
      chk("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
